dtw_stream_core: RTL and testbench

Parametrised successor to the fixed 250-PE DTW datapath. It computes subsequence DTW of a runtime-length query, up to `NPE` samples, against a streamed reference. The PEs form a systolic array with a valid/ready handshake on both query and reference inputs. It reports the minimum last-row cost and its end position, and can reuse a loaded query across references. It sits between the squiggle/reference fetch units and the hit-reporting logic.

---
 rtl/dtw_stream_core.sv | 255 +++++++++++++++++++++++++
 tb/tb_dtw_stream_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dtw_stream_core.sv
// dtw_stream_core: subsequence DTW of a runtime-length query (1..NPE samples)
// against a streamed reference. The engine is a systolic array of NPE processing elements.
// The core reports the minimum last-row cost and the 0-based reference index where it ended.
//
// Optional feature: define DTW_HIT_THRESH_EN to build the threshold comparator that drives
// `hit`. With the macro undefined, `hit` is tied low and `thresh` is ignored.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, keep_qry      job start pulse; reuse stored query when keep_qry=1
//   qry_len              query length (0 -> 1, > NPE -> NPE), sampled with start
//   q_valid/q_ready/q_data                  query stream (LOAD state)
//   r_valid/r_ready/r_data/r_last           reference stream (RUN state)
//   thresh               hit threshold
//   min_val, min_pos, min_valid, hit        best last-row cost and its end column
//   busy, done           job status
module dtw_stream_core #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NPE   = 256,
    parameter int unsigned LW    = $clog2(NPE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             keep_qry,
    input  logic [LW-1:0]    qry_len,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [WIDTH-1:0] q_data,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [WIDTH-1:0] r_data,
    input  logic             r_last,
    input  logic [WIDTH-1:0] thresh,
    output logic [WIDTH-1:0] min_val,
    output logic [31:0]      min_pos,
    output logic             min_valid,
    output logic             hit,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] Inf = '1;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] qlen_q, cnt_q, qlen_new;
    logic          q_ready_q, r_ready_q, busy_q, done_q;

    // Array storage; element i is PE k=i+1.
    logic [WIDTH-1:0] qbuf_q  [NPE];
    logic [WIDTH-1:0] y_q     [NPE];
    logic [WIDTH-1:0] prev_q  [NPE];
    logic [WIDTH-1:0] pprev_q [NPE];
    logic [WIDTH-1:0] n_w     [NPE];
    logic [WIDTH-1:0] nw_w    [NPE];
    logic [WIDTH-1:0] d_w     [NPE];
    logic [NPE-1:0]   v_q;

    logic             start_ok, q_hs, r_hs, step, inject_v;
    logic [WIDTH-1:0] last_d, last_val_q, min_val_q;
    logic             last_vd, last_v_q, min_valid_q, hit_q, hit_new;
    logic [31:0]      col_q, min_pos_q;

    // Saturating cost cell: |x-y| + min(W, N, NW).
    function automatic logic [WIDTH-1:0] pe_cost(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] w,
                                                 input logic [WIDTH-1:0] n,
                                                 input logic [WIDTH-1:0] nw);
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] m;
        logic [WIDTH:0]   s;
        c = (x > y) ? (x - y) : (y - x);
        m = w;
        if (n < m)  m = n;
        if (nw < m) m = nw;
        s = {1'b0, c} + {1'b0, m};
        return s[WIDTH] ? Inf : s[WIDTH-1:0];
    endfunction

    assign start_ok = start & ((state_q == StIdle) | (state_q == StDone));
    assign q_hs     = q_ready_q & q_valid;
    // r_ready_q is high exactly in RUN, so r_hs is the RUN step condition.
    assign r_hs     = r_ready_q & r_valid;
    assign step     = r_hs | (state_q == StDrain);
    assign inject_v = (state_q == StRun);

    always_comb begin
        qlen_new = qry_len;
        if (qry_len == '0) begin
            qlen_new = LW'(1);
        end else if (qry_len > LW'(NPE)) begin
            qlen_new = LW'(NPE);
        end
    end

    // ---------------------------------------------------------------- control FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (start) state_d = keep_qry ? StRun : StLoad;
            StLoad:  if (q_hs && cnt_q == qlen_q - LW'(1)) state_d = StRun;
            StRun:   if (r_hs && r_last) state_d = StDrain;
            // Q bubble steps flush the last column to PE Q; one more cycle lets the
            // min register absorb it, so done rises together with the final min_*.
            StDrain: if (cnt_q == qlen_q) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            qlen_q    <= LW'(1);
            cnt_q     <= '0;
            q_ready_q <= 1'b0;
            r_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_ready_q <= (state_d == StLoad);
            r_ready_q <= (state_d == StRun);
            busy_q    <= (state_d == StLoad) | (state_d == StRun) | (state_d == StDrain);
            done_q    <= (state_d == StDone);
            if (start_ok) begin
                cnt_q <= '0;
                if (!keep_qry) qlen_q <= qlen_new;
            end else if (state_q == StLoad) begin
                if (q_hs) cnt_q <= (state_d == StRun) ? '0 : cnt_q + LW'(1);
            end else if (state_q == StDrain) begin
                cnt_q <= cnt_q + LW'(1);
            end
        end
    end

    // ---------------------------------------------------------------- systolic array
    always_comb begin
        n_w[0]  = '0;
        nw_w[0] = '0;
        for (int i = 1; i < NPE; i++) begin
            n_w[i]  = prev_q[i-1];
            nw_w[i] = pprev_q[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < NPE; i++) begin
            d_w[i] = pe_cost(qbuf_q[i], y_q[i], prev_q[i], n_w[i], nw_w[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < NPE; i++) begin
                qbuf_q[i]  <= '0;
                y_q[i]     <= '0;
                prev_q[i]  <= Inf;
                pprev_q[i] <= Inf;
            end
        end else begin
            if (q_hs) begin
                for (int i = 0; i < NPE; i++) begin
                    if (LW'(i) == cnt_q) qbuf_q[i] <= q_data;
                end
            end
            if (start_ok) begin
                v_q <= '0;
                for (int i = 0; i < NPE; i++) begin
                    prev_q[i]  <= Inf;
                    pprev_q[i] <= Inf;
                end
            end else if (step) begin
                y_q[0] <= r_data;
                v_q[0] <= inject_v;
                for (int i = 1; i < NPE; i++) begin
                    y_q[i] <= y_q[i-1];
                    // PEs beyond the active query length never see a valid sample.
                    v_q[i] <= v_q[i-1] & (LW'(i) < qlen_q);
                end
                for (int i = 0; i < NPE; i++) begin
                    if (v_q[i]) begin
                        prev_q[i]  <= d_w[i];
                        pprev_q[i] <= prev_q[i];
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- last row / minimum
    always_comb begin
        last_d  = Inf;
        last_vd = 1'b0;
        for (int i = 0; i < NPE; i++) begin
            if (LW'(i + 1) == qlen_q) begin
                last_d  = d_w[i];
                last_vd = v_q[i];
            end
        end
    end

`ifdef DTW_HIT_THRESH_EN
    assign hit_new = (last_val_q <= thresh);
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign hit_new       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_v_q    <= 1'b0;
            last_val_q  <= Inf;
            col_q       <= '0;
            min_val_q   <= Inf;
            min_pos_q   <= '0;
            min_valid_q <= 1'b0;
            hit_q       <= 1'b0;
        end else if (start_ok) begin
            last_v_q    <= 1'b0;
            col_q       <= '0;
            min_val_q   <= Inf;
            min_pos_q   <= '0;
            min_valid_q <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            last_v_q <= step & last_vd;
            if (step & last_vd) last_val_q <= last_d;
            // Last-row values emerge in column order, so a local counter tracks j.
            if (last_v_q) begin
                col_q <= col_q + 32'd1;
                if (!min_valid_q || last_val_q < min_val_q) begin
                    min_val_q   <= last_val_q;
                    min_pos_q   <= col_q;
                    min_valid_q <= 1'b1;
                    hit_q       <= hit_new;
                end
            end
        end
    end

    assign q_ready   = q_ready_q;
    assign r_ready   = r_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign min_val   = min_val_q;
    assign min_pos   = min_pos_q;
    assign min_valid = min_valid_q;
    assign hit       = hit_q;

endmodule

// File: tb/tb_dtw_stream_core.sv
// Bench for dtw_stream_core: a 16-bit and an 8-bit instance (NPE=4) share all stimulus.
// Jobs come from a table; a reset-mid-run sequence is written out by hand.
module tb_dtw_stream_core;

    localparam int NPE = 4;
    localparam int LW  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, keep_qry = 1'b0;
    logic [LW-1:0] qry_len = '0;
    logic          q_valid = 1'b0, r_valid = 1'b0, r_last = 1'b0;
    logic [15:0]   q_data = '0, r_data = '0, thresh = '0;

    logic          q_ready, r_ready, min_valid, hit, busy, done;
    logic [15:0]   min_val;
    logic [31:0]   min_pos;
    logic          q_ready8, r_ready8, min_valid8, hit8, busy8, done8;
    logic [7:0]    min_val8;
    logic [31:0]   min_pos8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dtw_stream_core #(.WIDTH(16), .NPE(NPE), .LW(LW)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .keep_qry(keep_qry), .qry_len(qry_len),
        .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
        .thresh(thresh), .min_val(min_val), .min_pos(min_pos), .min_valid(min_valid),
        .hit(hit), .busy(busy), .done(done)
    );

    dtw_stream_core #(.WIDTH(8), .NPE(NPE), .LW(LW)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .keep_qry(keep_qry), .qry_len(qry_len),
        .q_valid(q_valid), .q_ready(q_ready8), .q_data(q_data[7:0]),
        .r_valid(r_valid), .r_ready(r_ready8), .r_data(r_data[7:0]), .r_last(r_last),
        .thresh(thresh[7:0]), .min_val(min_val8), .min_pos(min_pos8), .min_valid(min_valid8),
        .hit(hit8), .busy(busy8), .done(done8)
    );

    typedef struct {
        int qlen_in;  // value driven on qry_len
        int eq;       // effective query length
        int q[4];
        int rlen;
        int r[6];
        bit keep;
        bit stall;
        int th;
        int ev;       // expected min_val, 16-bit instance
        int ep;       // expected min_pos
        int ev8;      // expected min_val, 8-bit instance
    } job_t;

    job_t jobs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input job_t j);
        @(negedge clk);
        thresh   = 16'(j.th);
        start    = 1'b1;
        keep_qry = j.keep;
        qry_len  = LW'(j.qlen_in);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic do_load(input job_t j);
        int  i = 0;
        int  tmo = 0;
        bit  hs;
        while (i < j.eq && tmo < 100) begin
            q_valid = 1'b1;
            q_data  = 16'(j.q[i]);
            hs      = q_ready;
            @(negedge clk);
            if (hs) i++;
            tmo++;
        end
        q_valid = 1'b0;
        check("load_count", i, j.eq);
    endtask

    task automatic run_job(input int idx, input job_t j);
        int  i = 0;
        int  tmo = 0;
        int  e_last = 0;
        bit  hs;
        bit  qr_seen = 1'b0;
        bit  eh, eh8;
        do_start(j);
        if (!j.keep) do_load(j);
        while (i < j.rlen && tmo < 300) begin
            r_valid = j.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            r_data  = 16'(j.r[i]);
            r_last  = (i == j.rlen - 1);
            hs      = r_valid & r_ready;
            if (q_ready) qr_seen = 1'b1;
            if (hs && r_last) e_last = cyc + 1;
            @(negedge clk);
            if (hs) i++;
            tmo++;
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        check("ref_count", i, j.rlen);
        tmo = 0;
        while (!done && tmo < 100) begin
            if (q_ready) qr_seen = 1'b1;
            @(negedge clk);
            tmo++;
        end
        check("done_seen", done, 1);
        if (!j.stall) check("done_latency", cyc - e_last, j.eq + 1);
        if (j.keep) check("q_ready_idle_on_keep", qr_seen, 0);
`ifdef DTW_HIT_THRESH_EN
        eh  = (j.ev <= j.th);
        eh8 = (j.ev8 <= (j.th & 255));
`else
        eh  = 1'b0;
        eh8 = 1'b0;
`endif
        check($sformatf("job%0d_min_val", idx), min_val, j.ev);
        check($sformatf("job%0d_min_pos", idx), min_pos, j.ep);
        check($sformatf("job%0d_min_valid", idx), min_valid, 1);
        check($sformatf("job%0d_hit", idx), hit, eh);
        check($sformatf("job%0d_busy", idx), busy, 0);
        check($sformatf("job%0d_min_val8", idx), min_val8, j.ev8);
        check($sformatf("job%0d_min_pos8", idx), min_pos8, j.ep);
        check($sformatf("job%0d_hit8", idx), hit8, eh8);
        check($sformatf("job%0d_done8", idx), done8, 1);
        repeat (3) @(negedge clk);
        check($sformatf("job%0d_min_val_stable", idx), min_val, j.ev);
        check($sformatf("job%0d_done_stable", idx), done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q_ready"}, q_ready, 0);
        check({tag, "_r_ready"}, r_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_min_val"}, min_val, 16'hffff);
        check({tag, "_min_pos"}, min_pos, 0);
        check({tag, "_min_valid"}, min_valid, 0);
        check({tag, "_hit"}, hit, 0);
        check({tag, "_min_val8"}, min_val8, 8'hff);
    endtask

    initial begin
        //          qlen eq  q              rl r                    kp st th  ev   ep ev8
        jobs[0] = '{3, 3, '{3, 5, 7, 0}, 5, '{0, 3, 5, 7, 9, 0}, 0, 0, 0,   0,   3, 0};
        jobs[1] = '{3, 3, '{3, 5, 7, 0}, 5, '{0, 3, 5, 7, 9, 0}, 0, 1, 0,   0,   3, 0};
        jobs[2] = '{0, 3, '{0, 0, 0, 0}, 4, '{9, 3, 5, 7, 0, 0}, 1, 0, 5,   0,   3, 0};
        jobs[3] = '{1, 1, '{1, 0, 0, 0}, 3, '{1, 4, 1, 0, 0, 0}, 0, 0, 0,   0,   0, 0};
        jobs[4] = '{0, 1, '{6, 0, 0, 0}, 3, '{2, 9, 6, 0, 0, 0}, 0, 0, 0,   0,   2, 0};
        jobs[5] = '{3, 3, '{3, 5, 7, 0}, 1, '{10, 0, 0, 0, 0, 0}, 0, 0, 14, 15,  0, 15};
        jobs[6] = '{7, 4, '{1, 2, 3, 4}, 4, '{1, 2, 3, 4, 0, 0}, 0, 0, 1,   0,   3, 0};
        jobs[7] = '{2, 2, '{0, 0, 0, 0}, 2, '{200, 200, 0, 0, 0, 0}, 0, 0, 300, 400, 0, 255};
        jobs[8] = '{1, 1, '{0, 0, 0, 0}, 2, '{7, 2, 0, 0, 0, 0}, 1, 0, 2,   2,   1, 2};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) run_job(k, jobs[k]);

        // Mid-RUN: ignored start, then asynchronous reset between clock edges.
        do_start(jobs[0]);
        do_load(jobs[0]);
        for (int k = 0; k < 4; k++) begin
            r_valid = 1'b1;
            r_data  = 16'(jobs[0].r[k]);
            @(negedge clk);
        end
        r_valid  = 1'b0;
        start    = 1'b1;
        keep_qry = 1'b0;
        qry_len  = LW'(1);
        @(negedge clk);
        start = 1'b0;
        check("busy_start_ignored", busy, 1);
        check("q_ready_start_ignored", q_ready, 0);
        check("r_ready_start_ignored", r_ready, 1);
        check("partial_min_valid", min_valid, 1);
        check("partial_min_val", min_val, 15);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // keep_qry after reset: stored query is length 1 with sample 0.
        run_job(8, jobs[8]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
